// File: rtl/mul_mod2np1_seq.sv
// Sequential multiplier modulo 2^width+1 on diminished-one operands, built as an
// MSB-first double-and-add loop around a single shared diminished-one adder.
package lau_pkg;
    typedef enum logic {FAST, SMALL} speed_e;
endpackage

// Diminished-one adder for nonzero operands: s' = a' + b' + ~carry (end-around).
module add_mod2np1 #(
    parameter int              width = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic [width-1:0] s_o
);
    logic [width:0] raw;

    assign raw = {1'b0, a_i} + {1'b0, b_i};

    generate
        if (speed == lau_pkg::FAST) begin : g_fast
            logic [width-1:0] inc;
            assign inc = raw[width-1:0] + {{(width-1){1'b0}}, 1'b1};
            assign s_o = raw[width] ? raw[width-1:0] : inc;
        end else begin : g_small
            assign s_o = raw[width-1:0] + {{(width-1){1'b0}}, ~raw[width]};
        end
    endgenerate
endmodule

module mul_mod2np1_seq #(
    parameter int              width = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [width-1:0] a_i,
    input  logic             a_zero_i,
    input  logic [width-1:0] b_i,
    input  logic             b_zero_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [width-1:0] s_o,
    output logic             s_zero_o,
    output logic             busy_o
);
    // state | meaning
    // IDLE  | waiting for operands, in_ready_o high
    // DBL   | R = 2R (skipped while R is true zero)
    // ADD   | R = R + A when bit idx of the true B is set
    // DONE  | result held until out_ready_i
    typedef enum logic [1:0] {IDLE, DBL, ADD, DONE} state_t;

    localparam int IW = $clog2(width + 1);

    state_t           state;
    logic [width-1:0] r;
    logic             rz;
    logic [width-1:0] areg;
    logic [width:0]   bv;
    logic [IW-1:0]    idx;

    logic [width-1:0] add_b;
    logic [width-1:0] sum;
    logic [width-1:0] r_nxt;
    logic             rz_nxt;

    assign add_b = (state == ADD) ? areg : r;

    add_mod2np1 #(
        .width(width),
        .speed(speed)
    ) u_add (
        .a_i(r),
        .b_i(add_b),
        .s_o(sum)
    );

    // r + a == 2^width - 1 exactly when r is the bitwise complement of a; the
    // true sum is then p, i.e. zero, which the diminished adder cannot represent.
    always_comb begin
        r_nxt  = r;
        rz_nxt = rz;
        if (bv[idx]) begin
            if (rz) begin
                r_nxt  = areg;
                rz_nxt = 1'b0;
            end else if (&(r ^ areg)) begin
                r_nxt  = '0;
                rz_nxt = 1'b1;
            end else begin
                r_nxt = sum;
            end
        end
    end

    assign in_ready_o = (state == IDLE);
    assign busy_o     = (state == DBL) || (state == ADD);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            r           <= '0;
            rz          <= 1'b0;
            areg        <= '0;
            bv          <= '0;
            idx         <= '0;
            s_o         <= '0;
            s_zero_o    <= 1'b0;
            out_valid_o <= 1'b0;
        end else if (flush_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        areg <= a_i;
                        bv   <= {1'b0, b_i} + {{width{1'b0}}, 1'b1};
                        if (a_zero_i || b_zero_i) begin
                            s_o         <= '0;
                            s_zero_o    <= 1'b1;
                            out_valid_o <= 1'b1;
                            state       <= DONE;
                        end else begin
                            r     <= '0;
                            rz    <= 1'b1;
                            idx   <= IW'(width);
                            state <= DBL;
                        end
                    end
                end
                DBL: begin
                    if (!rz) begin
                        r <= sum;
                    end
                    state <= ADD;
                end
                ADD: begin
                    r  <= r_nxt;
                    rz <= rz_nxt;
                    if (idx == '0) begin
                        s_o         <= r_nxt;
                        s_zero_o    <= rz_nxt;
                        out_valid_o <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx   <= idx - IW'(1);
                        state <= DBL;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
